text_box_renderer: RTL
======================

// Module: text_box_renderer
// PURPOSE
//  Consumer end of the character-ROM interface. From VGA timing it computes the
//  {char_y, char_x} address (char_yx) sent to a character-code ROM and receives
//  char_code back. It then fetches the glyph row from a synchronous 8x16 font ROM
//  and overlays text pixels on the incoming RGB stream.
//  It sits in the video pipeline between the background/tile drawer and the VGA output.
// PARAMETERS
//  XPOS        256     left edge of text box, pixels
//  YPOS        200     top edge of text box, lines
//  COLS        17      characters per row (1..32)
//  ROWS        5       character rows (1..32)
//  TEXT_COLOR  12'hFFF colour of set glyph pixels
//  FILL_BG     0       1: clear glyph pixels in box drawn BG_COLOR; 0: rgb_in passes
//  BG_COLOR    12'h000 box background colour when FILL_BG=1
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous active-high reset
//  en           in   1   1: overlay text; 0: pure delayed pass-through (same latency)
//  hcount_in    in   11  horizontal pixel counter
//  vcount_in    in   11  vertical line counter
//  hsync_in     in   1   horizontal sync
//  vsync_in     in   1   vertical sync
//  hblnk_in     in   1   horizontal blanking
//  vblnk_in     in   1   vertical blanking
//  rgb_in       in   12  incoming pixel {r,g,b}
//  char_yx      out  10  {char_y[4:0], char_x[4:0]} address to char-code ROM (registered)
//  char_code    in   7   code from char-code ROM, valid 1 clk after char_yx
//  font_addr    out  11  {char_code[6:0], glyph_line[3:0]} to font ROM (combinational)
//  font_pixels  in   8   glyph row from font ROM, valid 1 clk after font_addr; bit7 = leftmost
//  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  as inputs
//  rgb_out      out  12  output pixel
// BEHAVIOUR
//  - Reset: all outputs and pipeline registers 0. Reset mid-frame discards in-flight
//    pixels. Outputs stay 0 until 4 clks after rst falls.
//  - Stage E1: rel_x = hcount_in-XPOS, rel_y = vcount_in-YPOS.
//    in_box = hcount_in in [XPOS, XPOS+8*COLS) && vcount_in in [YPOS, YPOS+16*ROWS)
//    (unsigned; no wrap below XPOS/YPOS).
//    char_yx <= in_box ? {rel_y[8:4], rel_x[7:3]} : 10'h000.
//    Stage 1 registers: timing, rgb, in_box, col = rel_x[2:0], line = rel_y[3:0].
//  - Stage E2: char ROM registers char_code. Delay line/col/in_box/timing/rgb one more stage.
//  - font_addr = {char_code, line_d2}, purely combinational from stage-2 values.
//  - Stage E3: font ROM registers font_pixels. Delay col/in_box/timing/rgb one more stage.
//  - Stage E4 (output register): all *_out are the E3 copies.
//    rgb_out selection:
//      hblnk|vblnk (stage 3)                          -> 12'h000
//      else en & in_box & font_pixels[7-col]          -> TEXT_COLOR
//      else en & in_box & FILL_BG                     -> BG_COLOR
//      else                                           -> rgb stage 3
//  - Total latency, input to every output, is exactly 4 clks. All timing outputs are
//    delayed identically, so sync/blank alignment is preserved.
//  - No handshake. The char ROM and font ROM must each have exactly 1 clk registered latency.
//  - Box edge: the pixel at hcount = XPOS+8*COLS-1 is in_box; XPOS+8*COLS is not.
//    Same rule vertically. en is sampled at E1 and pipelined with the pixel.
// TESTING
//  1 hcount=XPOS, vcount=YPOS -> char_yx=10'h000 next clk;
//    hcount=XPOS+26, vcount=YPOS+37 -> char_yx=10'h043, and one clk later
//    font_addr line = 4'd5.
//  2 ROM model: yx 10'h003 -> code 71; font row = 8'b1000_0001.
//    Row YPOS, hcount XPOS+24..31 -> rgb_out=TEXT_COLOR at cols 0 and 7, rgb_in elsewhere,
//    4 clks later.
//  3 hcount=XPOS-1 and XPOS+8*COLS, rgb_in=12'h0F0, font all 1s -> char_yx=0,
//    rgb_out=12'h0F0 (not in box).
//  4 single-clk hsync/vblnk pulse at cycle k -> hsync_out/vblnk_out high at k+4 only;
//    rgb_out=0 while blanked.
//  5 en=0 with font all 1s inside box -> rgb_out equals rgb_in delayed 4 clks;
//    FILL_BG=1, font 0 -> BG_COLOR.
//  6 assert rst for 1 clk mid-line -> all outputs 0 the next clk; valid data resumes
//    4 clks after release.

Source files
------------

// File: rtl/text_box_renderer.sv
// -----------------------------------------------------------------------------
// text_box_renderer
//
// Overlays a rectangular box of 8x16 text glyphs on a VGA pixel stream.
// From the incoming timing it forms the {char_y, char_x} address for an
// external character-code ROM, forwards the returned code plus glyph line to
// an external font ROM, and selects the text colour wherever the fetched
// glyph bit is set. Both ROMs are expected to be synchronous with exactly one
// clock of registered latency; everything else is pipelined to match, so every
// output lags its input by exactly four clocks.
//
// Ports
//   clk, rst                 pixel clock, synchronous active-high reset
//   en                       1: overlay text, 0: delayed pass-through
//   hcount_in, vcount_in     pixel / line counters (11 bits)
//   hsync_in, vsync_in       sync strobes
//   hblnk_in, vblnk_in       blanking strobes
//   rgb_in                   incoming pixel {r,g,b}
//   char_yx                  registered {char_y[4:0], char_x[4:0]} to char ROM
//   char_code                code returned by char ROM (1 clk after char_yx)
//   font_addr                combinational {char_code, glyph_line} to font ROM
//   font_pixels              glyph row from font ROM (1 clk after font_addr),
//                            bit 7 is the leftmost pixel
//   *_out                    timing and pixel outputs, 4 clks after the inputs
// -----------------------------------------------------------------------------
module text_box_renderer #(
    parameter int unsigned XPOS       = 256,
    parameter int unsigned YPOS       = 200,
    parameter int unsigned COLS       = 17,
    parameter int unsigned ROWS       = 5,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF,
    parameter bit          FILL_BG    = 1'b0,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  char_yx,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Box limits, one bit wider than the counters so that XPOS+8*COLS near
    // the top of the counter range cannot wrap.
    localparam logic [11:0] X_LO = 12'(XPOS);
    localparam logic [11:0] X_HI = 12'(XPOS + 8 * COLS);
    localparam logic [11:0] Y_LO = 12'(YPOS);
    localparam logic [11:0] Y_HI = 12'(YPOS + 16 * ROWS);

    // Video timing bundle that travels with every pixel.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } tim_t;

    // Per-pixel pipeline payload: timing plus the overlay context.
    typedef struct packed {
        tim_t       tim;
        logic       in_box;
        logic       en;
        logic [2:0] col;
    } pix_t;

    // Half-open range test [lo, hi) on an unsigned counter.
    function automatic logic in_range(input logic [10:0] val,
                                      input logic [11:0] lo,
                                      input logic [11:0] hi);
        return ({1'b0, val} >= lo) && ({1'b0, val} < hi);
    endfunction

    // Glyph bit for a column; column 0 is the leftmost pixel (bit 7).
    function automatic logic glyph_bit(input logic [7:0] row,
                                       input logic [2:0] col);
        return row[3'd7 - col];
    endfunction

    logic [7:0] rel_x_s;
    logic [8:0] rel_y_s;
    logic       in_box_s;

    pix_t       s1_q, s1_d;
    pix_t       s2_q, s2_d;
    pix_t       s3_q, s3_d;
    logic [3:0] line1_q, line1_d;
    logic [3:0] line2_q, line2_d;
    logic [9:0] char_yx_q, char_yx_d;
    tim_t       out_q, out_d;

    // Box-relative coordinates; only the bits that address a 32x32 character
    // grid are kept, so the unused upper difference bits are dropped here.
    assign rel_x_s  = 8'(hcount_in - 11'(XPOS));
    assign rel_y_s  = 9'(vcount_in - 11'(YPOS));
    assign in_box_s = in_range(hcount_in, X_LO, X_HI) &&
                      in_range(vcount_in, Y_LO, Y_HI);

    // Next-state logic for all pipeline stages and the output pixel mux.
    always_comb begin
        s1_d      = '0;
        s2_d      = '0;
        s3_d      = '0;
        line1_d   = 4'd0;
        line2_d   = 4'd0;
        char_yx_d = 10'h000;
        out_d     = '0;

        // E1: capture the pixel and form the character address.
        s1_d.tim.hcount = hcount_in;
        s1_d.tim.vcount = vcount_in;
        s1_d.tim.hsync  = hsync_in;
        s1_d.tim.vsync  = vsync_in;
        s1_d.tim.hblnk  = hblnk_in;
        s1_d.tim.vblnk  = vblnk_in;
        s1_d.tim.rgb    = rgb_in;
        s1_d.in_box     = in_box_s;
        s1_d.en         = en;
        s1_d.col        = rel_x_s[2:0];
        line1_d         = rel_y_s[3:0];
        if (in_box_s) begin
            char_yx_d = {rel_y_s[8:4], rel_x_s[7:3]};
        end else begin
            char_yx_d = 10'h000;
        end

        // E2 / E3: plain delay while the two ROMs do their lookups.
        s2_d    = s1_q;
        line2_d = line1_q;
        s3_d    = s2_q;

        // E4: timing copies straight through, pixel is chosen by priority.
        out_d = s3_q.tim;
        if (s3_q.tim.hblnk || s3_q.tim.vblnk) begin
            out_d.rgb = 12'h000;
        end else if (s3_q.en && s3_q.in_box && glyph_bit(font_pixels, s3_q.col)) begin
            out_d.rgb = TEXT_COLOR;
        end else if (s3_q.en && s3_q.in_box && FILL_BG) begin
            out_d.rgb = BG_COLOR;
        end else begin
            out_d.rgb = s3_q.tim.rgb;
        end
    end

    // Pipeline and output registers; reset flushes every in-flight pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            line1_q   <= 4'd0;
            line2_q   <= 4'd0;
            char_yx_q <= 10'h000;
            out_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            line1_q   <= line1_d;
            line2_q   <= line2_d;
            char_yx_q <= char_yx_d;
            out_q     <= out_d;
        end
    end

    // char_code arrives aligned with stage 2, so the glyph line is taken from
    // the same stage; the font ROM then returns its row aligned with stage 3.
    assign font_addr  = {char_code, line2_q};
    assign char_yx    = char_yx_q;

    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

endmodule
